// File: rtl/fetch_buffer_if.sv
// ----------------------------------------------------------------------------
// fetch_buffer_if
//   Bundles the fetch front end's two handshakes into one interface: the
//   instruction-memory request/response channel and the decode channel,
//   which includes decode's redirect feedback (next_PC_select/target_PC).
//
//   Signals
//     imem_req_valid / imem_req_ready  request handshake, imem_addr = fetch PC
//     imem_rsp_valid / imem_rsp_data   in-order instruction words from memory
//     dec_valid / dec_ready            FIFO head handshake to decode
//     dec_PC / dec_instruction         FIFO head contents (NOP when empty)
//     next_PC_select / target_PC       redirect request from decode
//
//   Modports
//     master  the fetch buffer itself
//     slave   the environment (memory + decode)
// ----------------------------------------------------------------------------
interface fetch_buffer_if #(
  parameter int ADDRESS_BITS = 16
);

  logic                    imem_req_valid;
  logic                    imem_req_ready;
  logic [ADDRESS_BITS-1:0] imem_addr;
  logic                    imem_rsp_valid;
  logic [31:0]             imem_rsp_data;
  logic                    dec_valid;
  logic                    dec_ready;
  logic [ADDRESS_BITS-1:0] dec_PC;
  logic [31:0]             dec_instruction;
  logic                    next_PC_select;
  logic [ADDRESS_BITS-1:0] target_PC;

  modport master (
    output imem_req_valid,
    input  imem_req_ready,
    output imem_addr,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    output dec_valid,
    input  dec_ready,
    output dec_PC,
    output dec_instruction,
    input  next_PC_select,
    input  target_PC
  );

  modport slave (
    input  imem_req_valid,
    output imem_req_ready,
    input  imem_addr,
    output imem_rsp_valid,
    output imem_rsp_data,
    input  dec_valid,
    output dec_ready,
    input  dec_PC,
    input  dec_instruction,
    output next_PC_select,
    output target_PC
  );

endinterface

// File: rtl/fetch_buffer.sv
// ----------------------------------------------------------------------------
// fetch_buffer
//   Instruction-fetch front end. Holds the fetch PC, issues in-order requests
//   to a variable-latency instruction memory, buffers returned words in a
//   small FIFO and hands them to decode over a valid/ready handshake. A taken
//   redirect from decode flushes the FIFO, marks every in-flight request to be
//   discarded on return, and restarts fetch at target_PC.
//
//   Ports
//     clock  rising-edge system clock
//     reset  asynchronous, active-low reset
//     bus    fetch_buffer_if.master (memory request/response + decode side)
//
//   Parameters
//     ADDRESS_BITS  PC / address width (must match the interface)
//     DEPTH         FIFO entries and cap on outstanding + buffered (power of 2)
//     RESET_PC      fetch PC after reset
// ----------------------------------------------------------------------------
module fetch_buffer #(
  parameter int                      ADDRESS_BITS = 16,
  parameter int                      DEPTH        = 2,
  parameter logic [ADDRESS_BITS-1:0] RESET_PC     = '0
) (
  input logic             clock,
  input logic             reset,
  fetch_buffer_if.master  bus
);

  localparam int          PTR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CNT_BITS = $clog2(DEPTH) + 1;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic [ADDRESS_BITS-1:0] r_fetchPc;
  logic [CNT_BITS-1:0]     r_outstanding;
  logic [CNT_BITS-1:0]     r_drop;
  logic [CNT_BITS-1:0]     r_count;
  logic [PTR_BITS-1:0]     r_tagRd;
  logic [PTR_BITS-1:0]     r_tagWr;
  logic [PTR_BITS-1:0]     r_fifoRd;
  logic [PTR_BITS-1:0]     r_fifoWr;
  logic [ADDRESS_BITS-1:0] r_tagPc    [DEPTH];
  logic [ADDRESS_BITS-1:0] r_fifoPc   [DEPTH];
  logic [31:0]             r_fifoData [DEPTH];

  logic                    w_rspValid;
  logic                    w_rspDrop;
  logic                    w_push;
  logic                    w_decValid;
  logic                    w_pop;
  logic                    w_redirect;
  logic [CNT_BITS:0]       w_inUse;
  logic                    w_reqValid;
  logic                    w_accept;
  logic [CNT_BITS-1:0]     w_outNext;

  // A response with nothing outstanding is a protocol error and is ignored
  // entirely; otherwise it either retires a discarded request or is pushed.
  assign w_rspValid = bus.imem_rsp_valid & (r_outstanding != '0);
  assign w_rspDrop  = w_rspValid & (r_drop != '0);
  assign w_push     = w_rspValid & (r_drop == '0);

  assign w_decValid = (r_count != '0);
  assign w_pop      = w_decValid & bus.dec_ready;
  assign w_redirect = w_pop & bus.next_PC_select;

  // The cap counts both in-flight and buffered words, so every response is
  // guaranteed a FIFO slot. Gating with reset keeps the request low while the
  // block is held in reset.
  assign w_inUse    = {1'b0, r_outstanding} + {1'b0, r_count};
  assign w_reqValid = reset & (w_inUse < (CNT_BITS+1)'(DEPTH)) & ~w_redirect;
  assign w_accept   = w_reqValid & bus.imem_req_ready;

  assign w_outNext  = r_outstanding + CNT_BITS'(w_accept) - CNT_BITS'(w_rspValid);

  assign bus.imem_req_valid  = w_reqValid;
  assign bus.imem_addr       = r_fetchPc;
  assign bus.dec_valid       = w_decValid;
  assign bus.dec_PC          = w_decValid ? r_fifoPc[r_fifoRd] : '0;
  assign bus.dec_instruction = w_decValid ? r_fifoData[r_fifoRd] : NOP;

  // Control state. On a redirect the FIFO is emptied (a same-cycle push is
  // lost with it) and every request still in flight after this cycle's
  // response is marked for discard. The tag queue keeps running across a
  // redirect because dropped responses still consume their tags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_fetchPc     <= RESET_PC;
      r_outstanding <= '0;
      r_drop        <= '0;
      r_count       <= '0;
      r_tagRd       <= '0;
      r_tagWr       <= '0;
      r_fifoRd      <= '0;
      r_fifoWr      <= '0;
    end else begin
      r_outstanding <= w_outNext;
      if (w_accept) begin
        r_tagWr <= r_tagWr + PTR_BITS'(1);
      end
      if (w_rspValid) begin
        r_tagRd <= r_tagRd + PTR_BITS'(1);
      end
      if (w_redirect) begin
        r_fetchPc <= bus.target_PC;
        r_drop    <= w_outNext;
        r_count   <= '0;
        r_fifoRd  <= '0;
        r_fifoWr  <= '0;
      end else begin
        if (w_accept) begin
          r_fetchPc <= r_fetchPc + ADDRESS_BITS'(4);
        end
        if (w_rspDrop) begin
          r_drop <= r_drop - CNT_BITS'(1);
        end
        if (w_push) begin
          r_fifoWr <= r_fifoWr + PTR_BITS'(1);
        end
        if (w_pop) begin
          r_fifoRd <= r_fifoRd + PTR_BITS'(1);
        end
        if (w_push && !w_pop) begin
          r_count <= r_count + CNT_BITS'(1);
        end else if (!w_push && w_pop) begin
          r_count <= r_count - CNT_BITS'(1);
        end
      end
    end
  end

  // Storage needs no reset: entries are only read once the pointers and
  // count say they were written.
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_tagPc[r_tagWr] <= r_fetchPc;
    end
    if (w_push) begin
      r_fifoPc[r_fifoWr]   <= r_tagPc[r_tagRd];
      r_fifoData[r_fifoWr] <= bus.imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// ----------------------------------------------------------------------------
// tb_fetch_buffer
//   Self-checking bench for fetch_buffer. A small in-order memory model with
//   configurable latency answers requests; decode behaviour and redirects are
//   driven from the bench. A second instance with RESET_PC=0xFFF8 exercises
//   address wrap.
// ----------------------------------------------------------------------------
module tb_fetch_buffer;

  localparam int          AB  = 16;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  fetch_buffer_if #(.ADDRESS_BITS(AB)) bus ();
  fetch_buffer_if #(.ADDRESS_BITS(AB)) bus2 ();

  fetch_buffer #(.ADDRESS_BITS(AB), .DEPTH(2), .RESET_PC(16'h0000)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  fetch_buffer #(.ADDRESS_BITS(AB), .DEPTH(2), .RESET_PC(16'hFFF8)) dutWrap (
    .clock (clock),
    .reset (reset),
    .bus   (bus2)
  );

  typedef struct {
    logic          decReady;
    logic          expReqValid;
    logic [AB-1:0] expAddr;
    logic          expDecValid;
    logic [AB-1:0] expDecPc;
  } vec_t;

  int compared   = 0;
  int mismatched = 0;
  int cycle      = 0;

  logic [AB-1:0] memAddr [$];
  int            memDue  [$];
  logic [AB-1:0] wrapAddrs [$];
  logic          wrapLog = 1'b0;

  logic          ruleOn = 1'b0;
  logic [AB-1:0] ruleFrom [2];
  logic [AB-1:0] ruleTo   [2];

  logic          sDecValid;
  logic [AB-1:0] sDecPc;
  logic [31:0]   sDecInstr;
  logic          sReqValid;
  logic [AB-1:0] sAddr;
  logic          sRedirect;
  logic [AB-1:0] sTarget;

  // Instruction word the memory model returns for an address.
  function automatic logic [31:0] memWord(input logic [AB-1:0] pc);
    return {16'hA5C3, pc};
  endfunction

  // Expected program order: sequential unless a redirect rule matches.
  function automatic logic [AB-1:0] nextPc(input logic [AB-1:0] pc);
    if (ruleOn && pc == ruleFrom[0]) return ruleTo[0];
    if (ruleOn && pc == ruleFrom[1]) return ruleTo[1];
    return pc + 16'd4;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // One clock cycle, entered and left at the falling edge. lat=0 selects a
  // per-address variable latency of 1..3 cycles.
  task automatic applyStimulus(input logic decReady, input logic reqReady, input int lat);
    int l;
    if (memDue.size() > 0 && memDue[0] <= cycle) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = memWord(memAddr[0]);
      void'(memAddr.pop_front());
      void'(memDue.pop_front());
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'h0;
    end
    bus.dec_ready      = decReady;
    bus.imem_req_ready = reqReady;
    bus.next_PC_select = 1'b0;
    bus.target_PC      = '0;
    #1;
    sDecValid = bus.dec_valid;
    sDecPc    = bus.dec_PC;
    sDecInstr = bus.dec_instruction;
    sRedirect = 1'b0;
    if (ruleOn && sDecValid && decReady) begin
      for (int r = 0; r < 2; r++) begin
        if (sDecPc == ruleFrom[r]) begin
          bus.next_PC_select = 1'b1;
          bus.target_PC      = ruleTo[r];
          sRedirect          = 1'b1;
          sTarget            = ruleTo[r];
        end
      end
    end
    #1;
    sReqValid = bus.imem_req_valid;
    sAddr     = bus.imem_addr;
    if (sReqValid && reqReady) begin
      l = (lat == 0) ? 1 + int'((sAddr >> 2) % 3) : lat;
      memAddr.push_back(sAddr);
      memDue.push_back(cycle + l);
    end
    if (wrapLog && bus2.imem_req_valid && bus2.imem_req_ready) begin
      wrapAddrs.push_back(bus2.imem_addr);
    end
    @(posedge clock);
    cycle++;
    @(negedge clock);
  endtask

  // Hold reset with memory quiet, check the reset outputs, release on a
  // falling edge so the next applyStimulus is cycle 0.
  task automatic doReset();
    reset = 1'b0;
    memAddr.delete();
    memDue.delete();
    ruleOn             = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.imem_req_ready = 1'b0;
    bus.dec_ready      = 1'b0;
    bus.next_PC_select = 1'b0;
    bus.target_PC      = '0;
    repeat (2) @(negedge clock);
    #1;
    checkOutput("reset req_valid", bus.imem_req_valid, 0);
    checkOutput("reset dec_valid", bus.dec_valid, 0);
    checkOutput("reset dec_PC", bus.dec_PC, 0);
    checkOutput("reset dec_instruction", bus.dec_instruction, NOP);
    @(negedge clock);
    reset = 1'b1;
    cycle = 0;
  endtask

  // Run with decode always ready and two redirect rules, checking the popped
  // stream against program order and the restart address after a redirect.
  task automatic runRedirect(input string name, input int lat,
                             input logic [AB-1:0] aFrom, input logic [AB-1:0] aTo,
                             input logic [AB-1:0] bFrom, input logic [AB-1:0] bTo,
                             input logic [AB-1:0] lastPc);
    logic [AB-1:0] expPc;
    logic [AB-1:0] restartPc;
    logic          afterRedirect;
    logic          done;
    doReset();
    ruleFrom[0] = aFrom; ruleTo[0] = aTo;
    ruleFrom[1] = bFrom; ruleTo[1] = bTo;
    ruleOn        = 1'b1;
    expPc         = 16'h0000;
    restartPc     = '0;
    afterRedirect = 1'b0;
    done          = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      applyStimulus(1'b1, 1'b1, lat);
      if (afterRedirect) begin
        checkOutput({name, " restart req_valid"}, sReqValid, 1);
        checkOutput({name, " restart imem_addr"}, sAddr, restartPc);
        afterRedirect = 1'b0;
      end
      if (sRedirect) begin
        checkOutput({name, " redirect-cycle req_valid"}, sReqValid, 0);
        afterRedirect = 1'b1;
        restartPc     = sTarget;
      end
      if (sDecValid) begin
        checkOutput({name, " dec_PC order"}, sDecPc, expPc);
        checkOutput({name, " dec_instruction"}, sDecInstr, memWord(sDecPc));
        if (sDecPc == lastPc) done = 1'b1;
        expPc = nextPc(sDecPc);
      end
    end
    if (!done) begin
      mismatched++;
      $display("[TB] FAIL %s timeout: got no pop of %h, expected it within 400 cycles", name, lastPc);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected one before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Second instance: always-ready memory answering every cycle, decode
  // always ready. Only its request addresses are inspected.
  initial begin
    bus2.imem_req_ready = 1'b1;
    bus2.imem_rsp_valid = 1'b1;
    bus2.imem_rsp_data  = 32'h0000_0093;
    bus2.dec_ready      = 1'b1;
    bus2.next_PC_select = 1'b0;
    bus2.target_PC      = '0;
  end

  initial begin
    vec_t vecs [18];
    // Latency-1 memory, always ready. The cap counts the entry being popped,
    // so the steady pattern is two requests then one idle cycle.
    vecs[0]  = '{1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000};
    vecs[1]  = '{1'b1, 1'b1, 16'h0004, 1'b0, 16'h0000};
    vecs[2]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000};
    vecs[3]  = '{1'b1, 1'b1, 16'h0008, 1'b1, 16'h0004};
    vecs[4]  = '{1'b1, 1'b1, 16'h000C, 1'b0, 16'h0000};
    vecs[5]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0008};
    vecs[6]  = '{1'b1, 1'b1, 16'h0010, 1'b1, 16'h000C};
    vecs[7]  = '{1'b1, 1'b1, 16'h0014, 1'b0, 16'h0000};
    vecs[8]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0010};
    // Decode stalls five cycles: one more request fills the cap, head held.
    vecs[9]  = '{1'b0, 1'b1, 16'h0018, 1'b1, 16'h0014};
    vecs[10] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0014};
    vecs[11] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0014};
    vecs[12] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0014};
    vecs[13] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0014};
    // Release: buffered words drain in order, fetch resumes.
    vecs[14] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0014};
    vecs[15] = '{1'b1, 1'b1, 16'h001C, 1'b1, 16'h0018};
    vecs[16] = '{1'b1, 1'b1, 16'h0020, 1'b0, 16'h0000};
    vecs[17] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h001C};

    $display("[TB] start");
    doReset();
    wrapLog = 1'b1;
    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].decReady, 1'b1, 1);
      checkOutput($sformatf("vec%0d req_valid", i), sReqValid, vecs[i].expReqValid);
      if (vecs[i].expReqValid) begin
        checkOutput($sformatf("vec%0d imem_addr", i), sAddr, vecs[i].expAddr);
      end
      checkOutput($sformatf("vec%0d dec_valid", i), sDecValid, vecs[i].expDecValid);
      checkOutput($sformatf("vec%0d dec_PC", i), sDecPc, vecs[i].expDecPc);
      checkOutput($sformatf("vec%0d dec_instruction", i), sDecInstr,
                  vecs[i].expDecValid ? memWord(vecs[i].expDecPc) : NOP);
    end
    wrapLog = 1'b0;

    // Wrap instance: first three requests must be FFF8, FFFC, 0000.
    checkOutput("wrap request count>=3", (wrapAddrs.size() >= 3), 1);
    if (wrapAddrs.size() >= 3) begin
      checkOutput("wrap addr0", wrapAddrs[0], 16'hFFF8);
      checkOutput("wrap addr1", wrapAddrs[1], 16'hFFFC);
      checkOutput("wrap addr2", wrapAddrs[2], 16'h0000);
    end

    // JAL at 0x0114 to 0x0128 under variable latency; 0x0118 must never pop.
    runRedirect("jal", 0, 16'h0000, 16'h0110, 16'h0114, 16'h0128, 16'h0130);
    // JALR at 0x0094 to 0x0154 under a fixed 3-cycle latency.
    runRedirect("jalr", 3, 16'h0000, 16'h0088, 16'h0094, 16'h0154, 16'h015C);

    // Asynchronous reset between edges while the FIFO is full.
    doReset();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b1, 2);
    end
    checkOutput("pre-reset dec_valid", bus.dec_valid, 1);
    @(posedge clock);
    #2;
    reset = 1'b0;
    memAddr.delete();
    memDue.delete();
    bus.imem_rsp_valid = 1'b0;
    #1;
    checkOutput("async reset dec_valid", bus.dec_valid, 0);
    checkOutput("async reset req_valid", bus.imem_req_valid, 0);
    checkOutput("async reset dec_instruction", bus.dec_instruction, NOP);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    cycle = 0;
    bus.imem_req_ready = 1'b1;
    #1;
    checkOutput("post-reset req_valid", bus.imem_req_valid, 1);
    checkOutput("post-reset imem_addr", bus.imem_addr, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
